// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU with request/ready instruction and data buses.
// Each instruction is fetched, decoded, optionally reads M, executes, and
// optionally writes M. A and D updates are held back until the instruction
// commits, so the M address and the jump target always use the old A.
// Compile-time option: HACK_CPU_HALT_EN adds a HALT state that is entered on
// a taken self-jump. Without it, a self-jump simply keeps fetching and
// halted is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | first cycle after reset, no request
// FETCH  | instr_req high, waiting for instr_ready
// DECODE | A-instruction commits here; C-instruction picks READ or EXEC
// READ   | mem_rd high at address A, waiting for mem_ready
// EXEC   | ALU result and jump decision; commits unless M is a destination
// WRITE  | mem_wr high with R at address A; commits on mem_ready
// HALT   | (HACK_CPU_HALT_EN only) stopped after a taken self-jump
module hack_cpu_mc #(
  parameter int WIDTH = 16,
  parameter int AW    = 15
) (
  input  logic             clk,
  input  logic             reset,
  output logic             instr_req,
  output logic [AW-1:0]    instr_addr,
  input  logic             instr_ready,
  input  logic [WIDTH-1:0] instruction,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [AW-1:0]    pc,
  output logic             retired,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE
`ifdef HACK_CPU_HALT_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [AW-1:0] PC_ONE = AW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             jump_q, jump_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             retired_q, retired_d;

  // instruction field aliases
  logic             ir_is_c;
  logic             ir_a;
  logic             ir_zx, ir_nx, ir_zy, ir_ny, ir_f, ir_no;
  logic             ir_d1, ir_d2, ir_d3;
  logic             ir_j1, ir_j2, ir_j3;

  // ALU datapath
  logic [WIDTH-1:0] alu_x, alu_y, alu_f, alu_out;
  logic             alu_zr, alu_ng;
  logic             jump_cond;

  // commit control
  logic             commit;
  logic [WIDTH-1:0] commit_val;
  logic             commit_jump;
  logic [AW-1:0]    pc_inc;

  assign ir_is_c = (ir_q[WIDTH-1 -: 3] == 3'b111);
  assign ir_a    = ir_q[12];
  assign ir_zx   = ir_q[11];
  assign ir_nx   = ir_q[10];
  assign ir_zy   = ir_q[9];
  assign ir_ny   = ir_q[8];
  assign ir_f    = ir_q[7];
  assign ir_no   = ir_q[6];
  assign ir_d1   = ir_q[5];
  assign ir_d2   = ir_q[4];
  assign ir_d3   = ir_q[3];
  assign ir_j1   = ir_q[2];
  assign ir_j2   = ir_q[1];
  assign ir_j3   = ir_q[0];

  assign pc_inc  = pc_q + PC_ONE;

  // Hack ALU on D and either A or the latched M value
  always_comb begin
    alu_x = d_q;
    alu_y = ir_a ? m_q : a_q;
    if (ir_zx) alu_x = '0;
    if (ir_nx) alu_x = ~alu_x;
    if (ir_zy) alu_y = '0;
    if (ir_ny) alu_y = ~alu_y;
    alu_f   = ir_f ? (alu_x + alu_y) : (alu_x & alu_y);
    alu_out = ir_no ? ~alu_f : alu_f;
  end

  assign alu_zr    = (alu_out == '0);
  assign alu_ng    = alu_out[WIDTH-1];
  assign jump_cond = (ir_j1 && alu_ng) || (ir_j2 && alu_zr) || (ir_j3 && !alu_ng && !alu_zr);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state, register updates and commit
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    a_d         = a_q;
    d_d         = d_q;
    m_d         = m_q;
    r_d         = r_q;
    jump_d      = jump_q;
    pc_d        = pc_q;
    retired_d   = 1'b0;
    commit      = 1'b0;
    commit_val  = r_q;
    commit_jump = jump_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_ready) begin
          ir_d    = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir_is_c) begin
          a_d       = {1'b0, ir_q[WIDTH-2:0]};
          pc_d      = pc_inc;
          retired_d = 1'b1;
          state_d   = S_FETCH;
        end else if (ir_a) begin
          state_d = S_READ;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_READ: begin
        if (mem_ready) begin
          m_d     = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        r_d    = alu_out;
        jump_d = jump_cond;
        if (ir_d3) begin
          state_d = S_WRITE;
        end else begin
          commit      = 1'b1;
          commit_val  = alu_out;
          commit_jump = jump_cond;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          commit = 1'b1;
        end
      end
`ifdef HACK_CPU_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A and D still hold their pre-instruction values up to this point,
    // so the jump target below is the old A.
    if (commit) begin
      if (ir_d1) a_d = commit_val;
      if (ir_d2) d_d = commit_val;
      pc_d      = commit_jump ? a_q[AW-1:0] : pc_inc;
      retired_d = 1'b1;
      state_d   = S_FETCH;
`ifdef HACK_CPU_HALT_EN
      if (commit_jump && (a_q[AW-1:0] == pc_q)) begin
        state_d = S_HALT;
      end
`endif
    end
  end

  // architectural and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= '0;
      a_q       <= '0;
      d_q       <= '0;
      m_q       <= '0;
      r_q       <= '0;
      jump_q    <= 1'b0;
      pc_q      <= '0;
      retired_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      a_q       <= a_d;
      d_q       <= d_d;
      m_q       <= m_d;
      r_q       <= r_d;
      jump_q    <= jump_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // Strobes come straight from the state, so request, address and wdata stay
  // stable for the whole access; A is not written until commit.
  assign instr_req  = (state_q == S_FETCH);
  assign instr_addr = pc_q;
  assign mem_rd     = (state_q == S_READ);
  assign mem_wr     = (state_q == S_WRITE);
  assign mem_addr   = a_q[AW-1:0];
  assign mem_wdata  = r_q;
  assign pc         = pc_q;
  assign retired    = retired_q;

`ifdef HACK_CPU_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Testbench for hack_cpu_mc: directed programs plus a random program, with an
// instruction-level reference model and a ready/valid memory responder.
module tb_hack_cpu_mc;

  localparam int W    = 16;
  localparam int AW   = 15;
  localparam int ROMB = 6;

  logic          clk;
  logic          reset;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          instr_ready;
  logic [W-1:0]  instruction;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [AW-1:0] pc;
  logic          retired, halted;

  hack_cpu_mc #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ready(instr_ready),
    .instruction(instruction),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retired(retired), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memories seen by the DUT
  logic [W-1:0]  rom [2**ROMB];
  logic [W-1:0]  ram [2**AW];
  // reference model state
  logic [W-1:0]  m_ram [2**AW];
  logic [AW-1:0] m_pc;
  logic [W-1:0]  m_a, m_d;
  bit            m_halted;

  // responder settings and records
  bit            rand_en;
  int            fix_iw, fix_mw;
  int            waits_total;
  logic [AW-1:0] rq[$];
  logic [AW-1:0] wq_a[$];
  logic [W-1:0]  wq_d[$];

  int            n_checks, n_fail;
  int            retire_cycles[$];
  logic [AW-1:0] retire_pcs[$];
  logic [5:0]    comps [18];

`ifdef HACK_CPU_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [5:0] C_ZERO = 6'b101010;
  localparam logic [5:0] C_NEG1 = 6'b111010;
  localparam logic [5:0] C_D    = 6'b001100;
  localparam logic [5:0] C_A    = 6'b110000;
  localparam logic [5:0] C_AP1  = 6'b110111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] c_ins(input bit a, input logic [5:0] c,
                                         input logic [2:0] dd, input logic [2:0] j);
    logic [W-1:0] w;
    w = '0;
    for (int i = 13; i <= W-4; i++) w[i] = 1'($urandom);
    w[W-1 -: 3] = 3'b111;
    w[12:0] = {a, c, dd, j};
    return w;
  endfunction

  function automatic logic [W-1:0] rand_ins();
    logic [W-1:0] w;
    if ($urandom_range(0, 9) < 4) begin
      if ($urandom_range(0, 9) < 7) w = W'($urandom_range(0, 63));
      else begin
        w = W'($urandom);
        if (w[W-1 -: 3] == 3'b111) w[W-1] = 1'b0;
      end
    end else begin
      w = c_ins(1'($urandom), comps[$urandom_range(0, 17)], 3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
    end
    return w;
  endfunction

  // Hack computations by name: x is D, y is A or M
  function automatic logic [W-1:0] ref_comp(input logic [5:0] c, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    case (c)
      6'b101010: return '0;
      6'b111111: return W'(1);
      6'b111010: return '1;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return -x;
      6'b110011: return -y;
      6'b011111: return x + W'(1);
      6'b110111: return y + W'(1);
      6'b001110: return x - W'(1);
      6'b110010: return y - W'(1);
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 'x;
    endcase
  endfunction

  // execute one instruction in the model; base is its zero-wait cycle count
  task automatic model_step(output int base, output bit ewr, output logic [AW-1:0] ewa,
                            output logic [W-1:0] ewd, output bit erd, output logic [AW-1:0] era);
    logic [W-1:0]  ins, y, r;
    logic [AW-1:0] a_old;
    bit            taken;
    ins = rom[m_pc[ROMB-1:0]];
    ewr = 0; erd = 0; ewa = '0; ewd = '0; era = '0;
    a_old = m_a[AW-1:0];
    if (ins[W-1 -: 3] != 3'b111) begin
      m_a  = {1'b0, ins[W-2:0]};
      m_pc = m_pc + AW'(1);
      base = 2;
    end else begin
      erd = ins[12];
      era = a_old;
      y = ins[12] ? m_ram[a_old] : m_a;
      r = ref_comp(ins[11:6], m_d, y);
      taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == '0) || (ins[0] && $signed(r) > 0);
      if (ins[3]) begin
        ewr = 1; ewa = a_old; ewd = r;
        m_ram[a_old] = r;
      end
      base = 3 + int'(ins[12]) + int'(ins[3]);
      m_halted = HALT_EN && taken && (a_old == m_pc);
      m_pc = taken ? a_old : m_pc + AW'(1);
      if (ins[5]) m_a = r;
      if (ins[4]) m_d = r;
    end
  endtask

  // memory responder: wait states, random ready/data while idle
  initial begin
    int cnt, cur;
    cnt = 0; cur = -1;
    instr_ready = 0; mem_ready = 0; instruction = '0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        instr_ready = 0; mem_ready = 0; cnt = 0; cur = -1;
      end else if (instr_req || mem_rd || mem_wr) begin
        if (cur < 0) cur = rand_en ? int'($urandom_range(0, 3)) : (instr_req ? fix_iw : fix_mw);
        instr_ready = 1'($urandom);
        mem_ready   = 1'($urandom);
        instruction = W'($urandom);
        mem_rdata   = W'($urandom);
        if (cnt >= cur) begin
          if (instr_req) begin
            instr_ready = 1;
            instruction = rom[instr_addr[ROMB-1:0]];
          end else begin
            mem_ready = 1;
            mem_rdata = ram[mem_addr];
            if (mem_rd) rq.push_back(mem_addr);
            if (mem_wr) begin
              wq_a.push_back(mem_addr);
              wq_d.push_back(mem_wdata);
              ram[mem_addr] = mem_wdata;
            end
          end
          cnt = 0; cur = -1;
        end else begin
          if (instr_req) instr_ready = 0;
          else mem_ready = 0;
          cnt++;
          waits_total++;
        end
      end else begin
        instr_ready = 1'($urandom); mem_ready = 1'($urandom);
        instruction = W'($urandom); mem_rdata = W'($urandom);
        cnt = 0; cur = -1;
      end
    end
  end

  task automatic init_mem();
    logic [W-1:0] v;
    for (int i = 0; i < 2**AW; i++) begin
      v = W'($urandom);
      ram[i] = v; m_ram[i] = v;
    end
    for (int i = 0; i < 2**ROMB; i++) rom[i] = '0;
  endtask

  // one reset clock, then expect IDLE followed by the first fetch at 0
  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    chk("rst_instr_req", instr_req, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    reset = 0;
    m_pc = '0; m_a = '0; m_d = '0; m_halted = 0;
    rq.delete(); wq_a.delete(); wq_d.delete();
    @(posedge clk); #1;
    chk("first_instr_req", instr_req, 1);
    chk("first_instr_addr", instr_addr, 0);
  endtask

  // run until n_instr retire (or the model halts), checking every cycle
  task automatic run_prog(input int n_instr, input int budget);
    int cyc, last_cyc, last_waits, done, base;
    bit ewr, erd;
    logic [AW-1:0] ewa, era, prev_pc;
    logic [W-1:0] ewd;
    cyc = 0; last_cyc = 0; last_waits = waits_total; done = 0; prev_pc = pc;
    retire_cycles.delete(); retire_pcs.delete();
    while (done < n_instr && cyc < budget && !m_halted) begin
      @(posedge clk); #1;
      cyc++;
      chk("one_request", (int'(instr_req) + int'(mem_rd) + int'(mem_wr)) <= 1, 1);
      if (retired) begin
        model_step(base, ewr, ewa, ewd, erd, era);
        chk("retire_pc", pc, m_pc);
        chk("cycles_per_instr", cyc - last_cyc, base + waits_total - last_waits);
        chk("read_count", rq.size(), erd);
        if (erd && rq.size() > 0) chk("read_addr", rq.pop_front(), era);
        chk("write_count", wq_a.size(), ewr);
        if (ewr && wq_a.size() > 0) begin
          chk("write_addr", wq_a.pop_front(), ewa);
          chk("write_data", wq_d.pop_front(), ewd);
        end
        rq.delete(); wq_a.delete(); wq_d.delete();
        retire_cycles.push_back(cyc);
        retire_pcs.push_back(pc);
        last_cyc = cyc; last_waits = waits_total; done++;
      end else begin
        chk("pc_hold", pc, prev_pc);
      end
      chk("halted", halted, m_halted);
      if (instr_req) chk("fetch_addr", instr_addr, m_pc);
      if (mem_rd || mem_wr) chk("data_addr", mem_addr, m_a[AW-1:0]);
      prev_pc = pc;
    end
    chk("run_complete", (done == n_instr) || m_halted, 1);
  endtask

  initial begin
    int wcnt;
    logic [W-1:0] saved9;
    n_checks = 0; n_fail = 0; waits_total = 0;
    rand_en = 0; fix_iw = 0; fix_mw = 0;
    reset = 1;
    comps = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
              6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
              6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    // @5; D=A; @7; M=D with zero-wait memories
    init_mem();
    rom[0] = 16'h0005;
    rom[1] = c_ins(0, C_A, 3'b010, 3'b000);
    rom[2] = 16'h0007;
    rom[3] = c_ins(0, C_D, 3'b001, 3'b000);
    do_reset();
    run_prog(4, 40);
    chk("t1_retire0", retire_cycles[0], 2);
    chk("t1_retire1", retire_cycles[1], 5);
    chk("t1_retire2", retire_cycles[2], 7);
    chk("t1_retire3", retire_cycles[3], 11);
    chk("t1_ram7", ram[7], 16'd5);

    // @3; AM=M+1 with two wait cycles on read and write; then expose A
    init_mem();
    ram[3] = 16'd9; m_ram[3] = 16'd9;
    rom[0] = 16'h0003;
    rom[1] = c_ins(1, C_AP1, 3'b101, 3'b000);
    rom[2] = c_ins(0, C_A, 3'b010, 3'b000);
    rom[3] = 16'd40;
    rom[4] = c_ins(0, C_D, 3'b001, 3'b000);
    fix_mw = 2;
    do_reset();
    run_prog(5, 80);
    chk("t2_amm_cycles", retire_cycles[1] - retire_cycles[0], 9);
    chk("t2_ram3", ram[3], 16'd10);
    chk("t2_a_after", ram[40], 16'd10);
    fix_mw = 0;

    // D=-1; @20; D;JLT taken; @30; D;JGT not taken; store D
    init_mem();
    rom[0]  = c_ins(0, C_NEG1, 3'b010, 3'b000);
    rom[1]  = 16'd20;
    rom[2]  = c_ins(0, C_D, 3'b000, 3'b100);
    rom[20] = 16'd30;
    rom[21] = c_ins(0, C_D, 3'b000, 3'b001);
    rom[22] = 16'd45;
    rom[23] = c_ins(0, C_D, 3'b001, 3'b000);
    do_reset();
    run_prog(7, 80);
    chk("t3_jlt_taken_pc", retire_pcs[2], 20);
    chk("t3_jgt_not_taken_pc", retire_pcs[4], 22);
    chk("t3_d_neg1", ram[45], 16'hFFFF);

    // @0x7FFF; D=A+1; M=D; A-instruction with top bit set; M=D
    init_mem();
    rom[0] = 16'h7FFF;
    rom[1] = c_ins(0, C_AP1, 3'b010, 3'b000);
    rom[2] = c_ins(0, C_D, 3'b001, 3'b000);
    rom[3] = 16'hA005;
    rom[4] = c_ins(0, C_D, 3'b001, 3'b000);
    fix_iw = 1;
    do_reset();
    run_prog(5, 80);
    chk("t4_wrap_d", ram[15'h7FFF], 16'h8000);
    chk("t4_a_top_bit", ram[15'h2005], 16'h8000);
    fix_iw = 0;

    // reset during a WRITE wait state
    init_mem();
    rom[0] = 16'd9;
    rom[1] = c_ins(0, C_A, 3'b010, 3'b000);
    rom[2] = c_ins(0, C_D, 3'b001, 3'b000);
    saved9 = ram[9];
    fix_mw = 6;
    do_reset();
    run_prog(2, 40);
    wcnt = 0;
    for (int i = 0; i < 30 && wcnt < 3; i++) begin
      @(posedge clk); #1;
      if (mem_wr) wcnt++;
    end
    chk("t5_write_wait_seen", wcnt, 3);
    chk("t5_no_write_done", wq_a.size(), 0);
    rom[0] = c_ins(0, C_D, 3'b001, 3'b000);
    fix_mw = 0;
    do_reset();
    chk("t5_ram9_untouched", ram[9], saved9);
    run_prog(1, 20);
    chk("t5_a_d_zero", ram[0], 16'd0);

    // self-jump: @4 at pc 3, 0;JMP at pc 4
    init_mem();
    rom[3] = 16'd4;
    rom[4] = c_ins(0, C_ZERO, 3'b000, 3'b111);
    do_reset();
`ifdef HACK_CPU_HALT_EN
    run_prog(5, 60);
    chk("t6_halt_model", m_halted, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t6_halt_quiet", {halted, instr_req, mem_rd, mem_wr, retired}, 5'b10000);
    end
`else
    run_prog(9, 80);
    chk("t6_loop_pc", pc, 4);
    chk("t6_loop_pc_hist", retire_pcs[7], 4);
`endif

    // random program with random wait states
    init_mem();
    for (int i = 0; i < 2**ROMB; i++) rom[i] = rand_ins();
    rand_en = 1;
    do_reset();
    run_prog(400, 8000);
    rand_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_cpu_mc.md
# hack_cpu_mc

Parametrised multi-cycle Hack CPU for the computer-architecture tier. It executes the standard Hack A- and C-instruction set at a configurable data width. Instruction and data memory are reached over ready/valid-style request buses with wait states, so the core can sit in front of slow or shared memories instead of single-cycle RAM/ROM. It is the drop-in core for systems where instruction ROM or data RAM cannot answer combinationally.

## Interface
- WIDTH, 16: data, instruction, A, D and ALU width; legal range 16..32.
- AW, 15: width of pc, instr_addr and mem_addr; legal range ≤ WIDTH-1. Addresses are A[AW-1:0].
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; one clock with reset high fully reinitialises the core.
- instr_req  out  1  instruction fetch request.
- instr_addr  out  AW  fetch address; equals pc.
- instr_ready  in  1  fetch completes on a rising edge where instr_req && instr_ready.
- instruction  in  WIDTH  fetched word; sampled in the completing cycle.
- mem_rd  out  1  data read request.
- mem_wr  out  1  data write request.
- mem_addr  out  AW  data address.
- mem_wdata  out  WIDTH  write data; valid while mem_wr is high.
- mem_rdata  in  WIDTH  read data; sampled in the completing cycle.
- mem_ready  in  1  data access completes on a rising edge where (mem_rd || mem_wr) && mem_ready.
- pc  out  AW  address of the current or next instruction.
- retired  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped on a self-jump; tied 0 unless the halt feature is compiled in.

## Operation
- Decode
  - C-instruction: top three bits are 111. The low 13 bits use the Hack layout: a=bit12, c1..c6=bits11..6, d1..d3=bits5..3, j1..j3=bits2..0.
  - Bits WIDTH-4..13 are ignored.
  - Any other word is an A-instruction: A <= {1'b0, instruction[WIDTH-2:0]}.
- ALU: standard Hack zx/nx/zy/ny/f/no at WIDTH bits.
  - Addition wraps modulo 2^WIDTH.
  - zr means out==0. ng means out[WIDTH-1].
- Registers: IR, A, D, M-latch, pc, and ALU result register R.
- State machine: IDLE, FETCH, DECODE, READ, EXEC, WRITE, HALT.
  - IDLE -> FETCH unconditionally.
  - FETCH: instr_req=1. On instr_ready, latch IR and go to DECODE.
  - DECODE, A-instruction: load A, pc+1, pulse retired, go to FETCH.
  - DECODE, C-instruction with a=1: go to READ. Otherwise go to EXEC.
  - READ: mem_rd=1, mem_addr=A. On mem_ready, latch M and go to EXEC.
  - EXEC: compute R and the jump condition.
    - If d3=1, go to WRITE.
    - Otherwise commit and go to FETCH.
  - WRITE: mem_wr=1, mem_addr=A, mem_wdata=R. On mem_ready, commit and go to FETCH.
  - Commit:
    - d1 loads A from R; d2 loads D from R.
    - pc <= jump ? A_old : pc+1.
    - Pulse retired.
- Same-instruction read-before-write:
  - M address and jump target always use A as it was before the instruction.
  - A/D updates are deferred until commit.
- Jump condition: (j1&&ng) || (j2&&zr) || (j3&&!ng&&!zr).
- pc arithmetic wraps modulo 2^AW.
- Only one request is ever asserted at a time.
- Request, address and wdata are held stable until the completing edge.
- ready is ignored while no request is asserted. Ready may already be high in the first request cycle (zero-wait).

## Timing
- Reset values: state=IDLE, pc=0, A=0, D=0, all request strobes 0, retired=0, halted=0.
- The first instr_req occurs in the second cycle after reset deasserts.
- Cycles per instruction with zero-wait memories:
  - A-instruction: 2.
  - C-instruction without M: 3.
  - C-instruction reading M: 4.
  - C-instruction writing M: 4.
  - C-instruction reading and writing M: 5.
- Each ready-low cycle adds exactly one cycle.
- Reset mid-access: the in-flight request is abandoned.
  - Strobes are 0 in the cycle after the reset edge.
  - No register commit occurs from the abandoned instruction.
- retired is high in the cycle after the commit edge.
- pc changes only on commit or reset.

## Configuration
- HACK_CPU_HALT_EN defined:
  - On a commit where the jump is taken and A_old == pc of the committing instruction, the core enters HALT.
  - In HALT: halted=1, no further requests, and retired pulses once for that instruction.
  - Only reset leaves HALT.
- HACK_CPU_HALT_EN undefined:
  - No HALT state; a self-jump loops fetching forever.
  - halted is constant 0.

## Test plan
- Reset then program @5; D=A; @7; M=D, zero-wait memories:
  - RAM[7]=5, D=5.
  - retired pulses at cycles 2, 5, 7, 11 after first FETCH, matching the cycle counts above.
- AM=M+1 with A=3, RAM[3]=9, mem_ready held low 2 cycles on both read and write:
  - Write goes to address 3 with wdata=10.
  - A=10 afterwards.
  - Total 9 cycles.
- D=-1 then D;JLT with A=20, and D;JGT with A=30:
  - First jump taken, pc=20.
  - Second not taken, pc=next.
  - At WIDTH=24, D=0xFFFFFF and ng=1.
- WIDTH=32, AW=16, @0x7FFFFFFF then D=A+1:
  - D=0x80000000.
  - mem_addr shows 0xFFFF on a following M access.
- Reset asserted in the middle of a WRITE wait state:
  - mem_wr=0 the next cycle.
  - A, D and pc are 0.
  - No retired pulse.
  - Fetch restarts at address 0.
- With HACK_CPU_HALT_EN, @4 at pc 3; 0;JMP at pc 4:
  - halted=1 and instr_req stays 0 for 20 cycles.
  - Without the macro, instr_addr repeats 4.
